// File: rtl/stage2_window_gen_pkg.sv
// rtl/stage2_window_gen_pkg.sv - shared geometry and packing helper for the stage-2 window generator
package stage2_window_gen_pkg;

  // Kernel geometry and pixel width shared with the stage-2 convolution core
  localparam int ST2_KX       = 5;
  localparam int ST2_KY       = 5;
  localparam int ST2_CONV_IBW = 20;
  // Stage-1 feature-map size seen by stage 2
  localparam int ST2_IMG_W    = 12;
  localparam int ST2_IMG_H    = 12;

  // LSB of window element (y,x) inside the packed fmap vector
  function automatic int fmap_lsb(input int y, input int x, input int kx, input int ibw);
    return (y * kx + x) * ibw;
  endfunction

endpackage

// File: rtl/stage2_window_gen_if.sv
// rtl/stage2_window_gen_if.sv - pixel-in / window-out bundle between stage 1, the window generator and the stage-2 kernel
interface stage2_window_gen_if
  import stage2_window_gen_pkg::*;
#(
  parameter int IBW = ST2_CONV_IBW,
  parameter int KX  = ST2_KX,
  parameter int KY  = ST2_KY
);

  logic                   i_in_valid;
  logic [IBW-1:0]         i_in_pixel;
  logic                   o_ot_valid;
  logic [KX*KY*IBW-1:0]   o_ot_fmap;
  logic                   o_ot_last;

  // Pixel source side
  modport master (
    output i_in_valid, i_in_pixel,
    input  o_ot_valid, o_ot_fmap, o_ot_last
  );

  // Window generator side
  modport slave (
    input  i_in_valid, i_in_pixel,
    output o_ot_valid, o_ot_fmap, o_ot_last
  );

endinterface

// File: rtl/stage2_line_buffer.sv
// rtl/stage2_line_buffer.sv - DEPTH-deep pixel delay line that advances only on enable
module stage2_line_buffer
  import stage2_window_gen_pkg::*;
#(
  parameter int IBW   = ST2_CONV_IBW,
  parameter int DEPTH = ST2_IMG_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [IBW-1:0] din,
  output logic [IBW-1:0] dout
);

  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH - 1);

  logic [IBW-1:0] mem_q [DEPTH];
  logic [PW-1:0]  ptr_q, ptr_d;

  // Read-before-write: the slot about to be overwritten holds the pixel from DEPTH pushes ago
  assign dout = mem_q[ptr_q];

  // Circular pointer advance on each push
  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
    end
  end

  // Pointer register; storage contents are left uninitialised on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Delay-line storage write
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/stage2_window_gen.sv
// rtl/stage2_window_gen.sv - raster-order 5x5 stride-1 window generator feeding the stage-2 kernel
module stage2_window_gen
  import stage2_window_gen_pkg::*;
#(
  parameter int IMG_W = ST2_IMG_W,
  parameter int IMG_H = ST2_IMG_H,
  parameter int KX    = ST2_KX,
  parameter int KY    = ST2_KY,
  parameter int IBW   = ST2_CONV_IBW
) (
  input  logic                clk,
  input  logic                reset,
  stage2_window_gen_if.slave  bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FW = KX * KY * IBW;

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KX - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KY - 1);

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [IBW-1:0] win_q [KY][KX];
  logic [IBW-1:0] win_d [KY][KX];
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic [FW-1:0]  fmap_q, fmap_d;

  logic [IBW-1:0] lb_in  [KY-1];
  logic [IBW-1:0] lb_out [KY-1];
  logic           lb_en;

  // A pixel arriving together with reset is dropped, so the delay lines must not move either
  assign lb_en = bus.i_in_valid && !reset;

  // Chain of line buffers: lb[0] takes the live pixel, each later stage takes the previous stage's output
  for (genvar k = 0; k < KY - 1; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_in[k] = bus.i_in_pixel;
    end else begin : g_tail
      assign lb_in[k] = lb_out[k-1];
    end
    stage2_line_buffer #(.IBW(IBW), .DEPTH(IMG_W)) u_lb (
      .clk   (clk),
      .reset (reset),
      .en    (lb_en),
      .din   (lb_in[k]),
      .dout  (lb_out[k])
    );
  end

  // Raster counters, window shift and emission gate for one accepted pixel
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    fmap_d  = fmap_q;
    if (bus.i_in_valid) begin
      for (int y = 0; y < KY; y++) begin
        for (int x = 0; x < KX - 1; x++) begin
          win_d[y][x] = win_q[y][x+1];
        end
      end
      // Newest column enters at x=KX-1; the deepest line buffer supplies the oldest row y=0
      for (int y = 0; y < KY - 1; y++) begin
        win_d[y][KX-1] = lb_out[KY-2-y];
      end
      win_d[KY-1][KX-1] = bus.i_in_pixel;

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      // Row/col gates hide stale previous-row and previous-frame data in the window
      if (row_q >= ROW_FIRST_WIN && col_q >= COL_FIRST_WIN) begin
        valid_d = 1'b1;
        last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
        for (int y = 0; y < KY; y++) begin
          for (int x = 0; x < KX; x++) begin
            fmap_d[fmap_lsb(y, x, KX, IBW) +: IBW] = win_d[y][x];
          end
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      fmap_q  <= '0;
      for (int y = 0; y < KY; y++) begin
        for (int x = 0; x < KX; x++) begin
          win_q[y][x] <= '0;
        end
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      fmap_q  <= fmap_d;
      win_q   <= win_d;
    end
  end

  assign bus.o_ot_valid = valid_q;
  assign bus.o_ot_last  = last_q;
  assign bus.o_ot_fmap  = fmap_q;

endmodule

// File: tb/tb_stage2_window_gen.sv
// tb/tb_stage2_window_gen.sv - self-checking bench for the stage-2 window generator
module tb_stage2_window_gen;

  localparam int W   = 12;
  localparam int H   = 12;
  localparam int KX  = 5;
  localparam int KY  = 5;
  localparam int IBW = 20;
  localparam int FW  = KX * KY * IBW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stage2_window_gen_if #(.IBW(IBW), .KX(KX), .KY(KY)) bus ();

  stage2_window_gen #(.IMG_W(W), .IMG_H(H), .KX(KX), .KY(KY), .IBW(IBW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [IBW-1:0] fld(input logic [FW-1:0] f, input int y, input int x);
    return f[(y*KX + x)*IBW +: IBW];
  endfunction

  // Reference model: keep the whole current frame and cut each window straight out of it
  logic [IBW-1:0] img [H][W];
  int             m_row = 0;
  int             m_col = 0;
  int             m_idx = 0;
  logic           exp_valid = 1'b0;
  logic           exp_last  = 1'b0;
  logic [FW-1:0]  exp_fmap  = '0;
  bit             armed     = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_row = 0; m_col = 0;
      exp_valid = 1'b0; exp_last = 1'b0; exp_fmap = '0;
      armed = 1'b1;
    end else begin
      exp_valid = 1'b0;
      exp_last  = 1'b0;
      if (bus.i_in_valid) begin
        img[m_row][m_col] = bus.i_in_pixel;
        m_idx = m_row * W + m_col;
        if (m_row >= KY - 1 && m_col >= KX - 1) begin
          exp_valid = 1'b1;
          exp_last  = (m_row == H - 1) && (m_col == W - 1);
          for (int y = 0; y < KY; y++)
            for (int x = 0; x < KX; x++)
              exp_fmap[(y*KX + x)*IBW +: IBW] = img[m_row-KY+1+y][m_col-KX+1+x];
        end
        if (m_col == W - 1) begin
          m_col = 0;
          m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
          m_col = m_col + 1;
        end
      end
    end
  end

  // Per-cycle compare plus a log of every emitted window
  logic [FW-1:0] s_fmap [$];
  bit            s_last [$];
  int            s_idx  [$];

  always @(negedge clk) begin
    if (armed) begin
      chk("valid", FW'(bus.o_ot_valid), FW'(exp_valid));
      chk("last",  FW'(bus.o_ot_last),  FW'(exp_last));
      chk("fmap",  bus.o_ot_fmap,       exp_fmap);
      if (bus.o_ot_valid) begin
        s_fmap.push_back(bus.o_ot_fmap);
        s_last.push_back(bus.o_ot_last);
        s_idx.push_back(m_idx);
      end
    end
  end

  task automatic step(input bit v, input logic [IBW-1:0] p);
    bus.i_in_valid = v;
    bus.i_in_pixel = p;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IBW-1:0] pv(input int mode, input int r, input int c);
    case (mode)
      0:       return IBW'(r*W + c);
      1:       return IBW'(1000 + r*W + c);
      default: return IBW'(-(r*W + c + 1));
    endcase
  endfunction

  task automatic frame(input int mode, input int gap, input int npix);
    for (int i = 0; i < npix; i++) begin
      while (int'($urandom_range(99)) < gap) step(1'b0, IBW'($urandom));
      step(1'b1, pv(mode, i / W, i % W));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, IBW'($urandom));
  endtask

  function automatic int last_count(input int from, input int to);
    int n = 0;
    for (int i = from; i < to; i++) n += int'(s_last[i]);
    return n;
  endfunction

  logic [FW-1:0] ref1 [$];
  int            n0;
  int            sum;

  initial begin
    bus.i_in_valid = 1'b0;
    bus.i_in_pixel = '0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset held 3 cycles with pixels offered: outputs stay 0 and nothing is counted
    for (int i = 0; i < 3; i++) begin
      step(1'b1, IBW'($urandom));
      chk("rst_hold_valid", FW'(bus.o_ot_valid), '0);
      chk("rst_hold_last",  FW'(bus.o_ot_last),  '0);
      chk("rst_hold_fmap",  bus.o_ot_fmap,       '0);
    end
    reset = 1'b0;

    // Plain frame, no gaps
    n0 = s_fmap.size();
    frame(0, 0, W*H);
    idle(3);
    chk("f1_count", FW'(s_fmap.size() - n0), FW'(64));
    if (s_fmap.size() - n0 == 64) begin
      chk("f1_first_idx", FW'(s_idx[n0]), FW'(52));
      chk("f1_first_00", FW'(fld(s_fmap[n0], 0, 0)), FW'(0));
      chk("f1_first_04", FW'(fld(s_fmap[n0], 0, 4)), FW'(4));
      chk("f1_first_40", FW'(fld(s_fmap[n0], 4, 0)), FW'(48));
      chk("f1_first_44", FW'(fld(s_fmap[n0], 4, 4)), FW'(52));
      chk("f1_last_00",  FW'(fld(s_fmap[n0+63], 0, 0)), FW'(91));
      chk("f1_last_44",  FW'(fld(s_fmap[n0+63], 4, 4)), FW'(143));
      chk("f1_last_flag", FW'(s_last[n0+63]), FW'(1));
      chk("f1_last_once", FW'(last_count(n0, n0 + 64)), FW'(1));
      for (int i = 0; i < 64; i++) ref1.push_back(s_fmap[n0+i]);
    end

    // Same frame with ~40% idle cycles must give identical windows in identical order
    n0 = s_fmap.size();
    frame(0, 40, W*H);
    idle(3);
    chk("f2_count", FW'(s_fmap.size() - n0), FW'(64));
    if (s_fmap.size() - n0 == 64 && ref1.size() == 64) begin
      for (int i = 0; i < 64; i++) chk("f2_same_window", s_fmap[n0+i], ref1[i]);
    end

    // Two back-to-back frames, second offset by 1000
    n0 = s_fmap.size();
    frame(0, 0, W*H);
    frame(1, 0, W*H);
    idle(3);
    chk("f3_count", FW'(s_fmap.size() - n0), FW'(128));
    if (s_fmap.size() - n0 == 128) begin
      chk("f3_w65_00", FW'(fld(s_fmap[n0+64], 0, 0)), FW'(1000));
      chk("f3_w65_44", FW'(fld(s_fmap[n0+64], 4, 4)), FW'(1052));
      chk("f3_last_twice", FW'(last_count(n0, n0 + 128)), FW'(2));
    end

    // Negative pixels: sign-exact fields and an all-ones-weight sum
    n0 = s_fmap.size();
    frame(2, 20, W*H);
    idle(3);
    chk("f4_count", FW'(s_fmap.size() - n0), FW'(64));
    if (s_fmap.size() - n0 == 64) begin
      chk("f4_first_00", FW'(fld(s_fmap[n0], 0, 0)), FW'(20'hFFFFF));
      sum = 0;
      for (int y = 0; y < KY; y++)
        for (int x = 0; x < KX; x++)
          sum += int'($signed(fld(s_fmap[n0], y, x)));
      chk("f4_first_sum", FW'(sum), FW'(-675));
      chk("f4_last_44", FW'(fld(s_fmap[n0+63], 4, 4)), FW'(20'hFFF70));
    end

    // Abort a frame after 30 pixels with reset, then a complete frame
    n0 = s_fmap.size();
    frame(0, 0, 30);
    reset = 1'b1;
    step(1'b1, IBW'($urandom));
    step(1'b1, IBW'($urandom));
    reset = 1'b0;
    chk("f5_aborted_none", FW'(s_fmap.size() - n0), FW'(0));
    n0 = s_fmap.size();
    frame(0, 0, W*H);
    idle(3);
    chk("f5_count", FW'(s_fmap.size() - n0), FW'(64));
    if (s_fmap.size() - n0 == 64) begin
      chk("f5_first_idx", FW'(s_idx[n0]), FW'(52));
      chk("f5_first_00", FW'(fld(s_fmap[n0], 0, 0)), FW'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage2_window_gen.md
# stage2_window_gen

Streaming 5x5 window generator feeding the stage-2 convolution kernel. Accepts the stage-1 feature map one signed pixel per cycle in raster order and emits every valid 5x5 neighbourhood (stride 1, no padding) as one packed vector on a single-cycle valid strobe. The output packing and strobe match the stage-2 kernel's fmap input exactly, so the kernel connects directly with no glue logic.

## Interface
- `IMG_W`, 12, input feature-map width in pixels
- `IMG_H`, 12, input feature-map height in pixels
- `KX`, 5, window width (from `defines_cnn_core.v`)
- `KY`, 5, window height (from `defines_cnn_core.v`)
- `IBW`, 20, pixel bit width; equals `ST2_Conv_IBW`
- `clk`  in  1  the block's only clock; all logic on the rising edge
- `reset`  in  1  synchronous reset, active-high
- `i_in_valid`  in  1  pixel strobe; the pixel is accepted on every `clk` edge where this is high
- `i_in_pixel`  in  IBW  signed pixel
- `o_ot_valid`  out  1  one-cycle strobe, one per window
- `o_ot_fmap`  out  KX*KY*IBW  packed window; element (y,x) at bits [(y*KX+x)*IBW +: IBW]
- `o_ot_last`  out  1  high together with `o_ot_valid` on the final window of a frame

## Operation
- Column counter `col` (0..IMG_W-1) and row counter `row` (0..IMG_H-1) advance only on accepted pixels. `col` wraps to 0 after IMG_W-1 and `row` increments. After the pixel at (IMG_H-1, IMG_W-1) both counters return to 0, and the next accepted pixel is pixel (0,0) of a new frame.
- Line storage: KY-1 chained line buffers, each IMG_W deep.
  - On every accepted pixel, the column vector {lb[KY-2] out, …, lb[0] out, i_in_pixel} is shifted into a KY x KX window register from the right, so x=KX-1 holds the newest column.
  - Also on every accepted pixel, the pixel is pushed into lb[0] and each lb[k] output is pushed into lb[k+1].
- Row mapping inside the window: y=0 is the oldest row (row-4) and y=KY-1 is the current row.
- Window emission: an accepted pixel at (row, col) with row ≥ KY-1 and col ≥ KX-1 completes a window. One window is emitted per such pixel, giving (IMG_H-KY+1)*(IMG_W-KX+1) = 64 windows per frame at the defaults.
- Pixels are sign-preserved. No arithmetic is performed; data is moved bit-exact.
- Window register contents at a row's first KX-1 columns hold stale or previous-row data. These are never emitted because of the col gate.
- A new frame needs no flush. Leftover line-buffer data is never emitted because of the row gate.

## Timing
- Reset (synchronous, `reset`=1 at a `clk` edge):
  - `o_ot_valid`=0, `o_ot_last`=0, `o_ot_fmap`=0.
  - `row`=`col`=0, window register cleared.
  - Line-buffer RAM contents are not cleared (don't care).
  - Reset mid-frame discards the partial frame. The first pixel accepted after reset deasserts is pixel (0,0).
- Latency: 1 cycle. If the pixel accepted at edge N completes a window, `o_ot_valid` and `o_ot_fmap` are high/valid during the cycle after edge N.
- `o_ot_valid` is never high for two windows from a single pixel. It drops the cycle after unless the next pixel also completes a window, so back-to-back strobes are legal.
- `o_ot_fmap` holds its last value while `o_ot_valid`=0.
- `i_in_valid` gaps of any length stall the counters, line buffers and window with no state change. The output is unaffected apart from the absent strobes.
- No backpressure: the downstream kernel accepts every strobe. Throughput is 1 pixel/cycle sustained.
- `reset` and `i_in_valid` high together: reset wins and the pixel is dropped.

## Structure
- `defines_cnn_core.v` supplies `KX`, `KY` and `ST2_Conv_IBW`. Add `ST2_IMG_W` and `ST2_IMG_H` there.
- One sub-module: `stage2_line_buffer` (IBW-wide, IMG_W-deep delay line advanced on an enable), instantiated KY-1 times.
- The top level holds the counters, the window register, the emission gate and the output registers.

## Test plan
- 12x12 frame, pixel value = row*12+col, no gaps → exactly 64 strobes.
  - First strobe 1 cycle after pixel 52 is accepted, with (0,0)=0, (0,4)=4, (4,0)=48, (4,4)=52.
  - Last strobe has (0,0)=91, (4,4)=143 and `o_ot_last`=1.
- Same frame with random `i_in_valid` gaps (about 40% idle) → the same 64 windows, bit-identical and in the same order; each strobe 1 cycle after its completing pixel.
- Two back-to-back frames, second with values +1000 → 128 strobes.
  - Window 65 has (0,0)=1000 and (4,4)=1052.
  - No window mixes frames.
  - `o_ot_last` fires exactly twice.
- Negative pixels (value −(row*12+col+1), e.g. 20'hFFFFF for −1) → window fields sign-exact. The kernel's accumulation with an all-ones weight equals the reference sum.
- Reset asserted after 30 pixels, then a full frame → no strobe during or after the aborted frame. Exactly 64 strobes follow, the first at pixel 52 of the new frame with (0,0)=0.
- Reset held 3 cycles with `i_in_valid`=1 → outputs 0 throughout and no pixel counted.
